// File: rtl/hart_ctrl_pkg.sv
// ============================================================================
// Module      : hart_ctrl_pkg
// Description : Shared state encoding, command codes and widths for the
//               hart run controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hart_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RST_SEQ  = 3'd0,
        ST_STOPPED  = 3'd1,
        ST_RUNNING  = 3'd2,
        ST_STEPPING = 3'd3,
        ST_HALTED   = 3'd4
    } hart_state_e;

    localparam logic [1:0] c_CMD_RUN   = 2'b00;
    localparam logic [1:0] c_CMD_STEP  = 2'b01;
    localparam logic [1:0] c_CMD_STOP  = 2'b10;
    localparam logic [1:0] c_CMD_RESET = 2'b11;

    // Reset-sequence counter width; covers RST_CYCLES up to 15.
    localparam int c_RST_CNT_W = 4;
    localparam int c_CNT_W     = 32;

endpackage

`default_nettype wire

// File: rtl/hart_run_counters.sv
// ============================================================================
// Module      : hart_run_counters
// Description : Enabled-cycle and retire counters with optional cycle-limit
//               compare and sticky timeout flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hart_run_counters
    import hart_ctrl_pkg::*;
#(
    parameter int unsigned CYCLE_LIMIT = 0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clr,
    input  logic               i_en,
    input  logic               i_retire_valid,
    output logic [c_CNT_W-1:0] o_cycle_count,
    output logic [c_CNT_W-1:0] o_retire_count,
    output logic               o_limit_hit,
    output logic               o_timeout
);

    logic [c_CNT_W-1:0] cycle_q, cycle_d;
    logic [c_CNT_W-1:0] retire_q, retire_d;
    logic               timeout_q, timeout_d;
    logic               w_limit_hit;

    generate
        if (CYCLE_LIMIT != 0) begin : g_limit
            // Fires in the enabled cycle whose increment reaches the limit.
            assign w_limit_hit = i_en && ((cycle_q + c_CNT_W'(1)) == c_CNT_W'(CYCLE_LIMIT));
        end else begin : g_no_limit
            assign w_limit_hit = 1'b0;
        end
    endgenerate

    always_comb begin
        cycle_d   = cycle_q;
        retire_d  = retire_q;
        timeout_d = timeout_q;
        if (i_clr) begin
            cycle_d   = '0;
            retire_d  = '0;
            timeout_d = 1'b0;
        end else if (i_en) begin
            cycle_d = cycle_q + c_CNT_W'(1);
            if (i_retire_valid) begin
                retire_d = retire_q + c_CNT_W'(1);
            end
            if (w_limit_hit) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cycle_q   <= '0;
            retire_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            cycle_q   <= cycle_d;
            retire_q  <= retire_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_cycle_count  = cycle_q;
    assign o_retire_count = retire_q;
    assign o_limit_hit    = w_limit_hit;
    assign o_timeout      = timeout_q;

endmodule

`default_nettype wire

// File: rtl/hart_run_ctrl.sv
// ============================================================================
// Module      : hart_run_ctrl
// Description : Host-commanded run/step/stop/reset controller for one hart.
//               Optional breakpoint support: define HART_RUN_CTRL_BKPT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hart_run_ctrl
    import hart_ctrl_pkg::*;
#(
    parameter int unsigned RST_CYCLES  = 2,
    parameter int unsigned CYCLE_LIMIT = 0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cmd_valid,
    input  logic [1:0]  i_cmd,
    output logic        o_cmd_ready,
    input  logic        i_retire_valid,
    input  logic        i_retire_halt,
    input  logic        i_retire_trap,
    input  logic [31:0] i_retire_pc,
`ifdef HART_RUN_CTRL_BKPT_EN
    input  logic        i_bkpt_en,
    input  logic [31:0] i_bkpt_pc,
    output logic        o_bkpt_hit,
`endif
    output logic        o_hart_rst,
    output logic        o_hart_en,
    output logic [2:0]  o_state,
    output logic [31:0] o_cycle_count,
    output logic [31:0] o_retire_count,
    output logic        o_trap_seen,
    output logic        o_timeout
);

    localparam logic [c_RST_CNT_W-1:0] c_RST_LOAD = c_RST_CNT_W'(RST_CYCLES - 1);

    hart_state_e              state_q, state_d;
    logic [c_RST_CNT_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic                     hart_en_q, hart_rst_q;
    logic                     trap_q, trap_d;

    logic w_ready, w_fire, w_run, w_step, w_stop, w_reset;
    logic w_ret, w_halt, w_limit, w_stop_cond, w_bkpt, w_clr;

    assign w_ready = (state_q != ST_RST_SEQ) && (state_q != ST_STEPPING);
    assign w_fire  = i_cmd_valid && w_ready;
    assign w_run   = w_fire && (i_cmd == c_CMD_RUN);
    assign w_step  = w_fire && (i_cmd == c_CMD_STEP);
    assign w_stop  = w_fire && (i_cmd == c_CMD_STOP);
    assign w_reset = w_fire && (i_cmd == c_CMD_RESET);

    // Retire inputs only count in cycles the hart was actually enabled.
    assign w_ret       = hart_en_q && i_retire_valid;
    assign w_halt      = w_ret && i_retire_halt;
    assign w_stop_cond = w_halt || w_limit;

    // Clearing on entry keeps stale counts from showing during RST_SEQ.
    assign w_clr = (state_d == ST_RST_SEQ);

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        case (state_q)
            ST_RST_SEQ: begin
                if (rst_cnt_q == '0) begin
                    state_d = ST_STOPPED;
                end else begin
                    rst_cnt_d = rst_cnt_q - c_RST_CNT_W'(1);
                end
            end
            ST_STOPPED: begin
                if (w_run) begin
                    state_d = ST_RUNNING;
                end else if (w_step) begin
                    state_d = ST_STEPPING;
                end
            end
            ST_RUNNING: begin
                if (w_stop_cond) begin
                    state_d = ST_HALTED;
                end else if (w_bkpt || w_stop) begin
                    state_d = ST_STOPPED;
                end
            end
            ST_STEPPING: begin
                state_d = w_stop_cond ? ST_HALTED : ST_STOPPED;
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_RST_SEQ;
            end
        endcase
        // A host reset overrides every other transition out of a ready state.
        if (w_reset || (state_d == ST_RST_SEQ && state_q != ST_RST_SEQ)) begin
            state_d   = ST_RST_SEQ;
            rst_cnt_d = c_RST_LOAD;
        end
    end

    always_comb begin
        trap_d = trap_q;
        if (w_clr) begin
            trap_d = 1'b0;
        end else if (w_ret && i_retire_trap) begin
            trap_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_RST_SEQ;
            rst_cnt_q  <= c_RST_LOAD;
            hart_en_q  <= 1'b0;
            hart_rst_q <= 1'b1;
            trap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_cnt_q  <= rst_cnt_d;
            hart_en_q  <= (state_d == ST_RUNNING) || (state_d == ST_STEPPING);
            hart_rst_q <= (state_d == ST_RST_SEQ);
            trap_q     <= trap_d;
        end
    end

`ifdef HART_RUN_CTRL_BKPT_EN
    logic bkpt_hit_q, bkpt_hit_d;

    assign w_bkpt = w_ret && i_bkpt_en && (i_retire_pc == i_bkpt_pc);

    always_comb begin
        bkpt_hit_d = bkpt_hit_q;
        if (w_clr || w_run || w_step) begin
            bkpt_hit_d = 1'b0;
        end
        if (w_bkpt && (state_d == ST_STOPPED)) begin
            bkpt_hit_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bkpt_hit_q <= 1'b0;
        end else begin
            bkpt_hit_q <= bkpt_hit_d;
        end
    end

    assign o_bkpt_hit = bkpt_hit_q;
`else
    logic w_unused_pc;
    assign w_unused_pc = ^i_retire_pc;
    assign w_bkpt      = 1'b0;
`endif

    hart_run_counters #(
        .CYCLE_LIMIT (CYCLE_LIMIT)
    ) u_counters (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_clr          (w_clr),
        .i_en           (hart_en_q),
        .i_retire_valid (i_retire_valid),
        .o_cycle_count  (o_cycle_count),
        .o_retire_count (o_retire_count),
        .o_limit_hit    (w_limit),
        .o_timeout      (o_timeout)
    );

    assign o_cmd_ready = w_ready;
    assign o_hart_rst  = hart_rst_q;
    assign o_hart_en   = hart_en_q;
    assign o_state     = state_q;
    assign o_trap_seen = trap_q;

endmodule

`default_nettype wire

// File: tb/tb_hart_run_ctrl.sv
// ============================================================================
// Module      : tb_hart_run_ctrl
// Description : Directed self-checking bench for hart_run_ctrl (unlimited and
//               CYCLE_LIMIT=5 instances driven from the same stimulus).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hart_run_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd = 2'b00;
    logic        retire_valid = 1'b0;
    logic        retire_halt = 1'b0;
    logic        retire_trap = 1'b0;
    logic [31:0] retire_pc = 32'h0;

    logic        cmd_ready, hart_rst, hart_en, trap_seen, timeout;
    logic [2:0]  state;
    logic [31:0] cyc, ret;
    logic        l_cmd_ready, l_hart_rst, l_hart_en, l_trap_seen, l_timeout;
    logic [2:0]  l_state;
    logic [31:0] l_cyc, l_ret;
`ifdef HART_RUN_CTRL_BKPT_EN
    logic        bkpt_en = 1'b0;
    logic [31:0] bkpt_pc = 32'h0;
    logic        bkpt_hit, l_bkpt_hit;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hart_run_ctrl #(.RST_CYCLES(2), .CYCLE_LIMIT(0)) dut (
        .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
        .o_cmd_ready(cmd_ready), .i_retire_valid(retire_valid),
        .i_retire_halt(retire_halt), .i_retire_trap(retire_trap),
        .i_retire_pc(retire_pc),
`ifdef HART_RUN_CTRL_BKPT_EN
        .i_bkpt_en(bkpt_en), .i_bkpt_pc(bkpt_pc), .o_bkpt_hit(bkpt_hit),
`endif
        .o_hart_rst(hart_rst), .o_hart_en(hart_en), .o_state(state),
        .o_cycle_count(cyc), .o_retire_count(ret), .o_trap_seen(trap_seen),
        .o_timeout(timeout)
    );

    hart_run_ctrl #(.RST_CYCLES(2), .CYCLE_LIMIT(5)) dut_lim (
        .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
        .o_cmd_ready(l_cmd_ready), .i_retire_valid(retire_valid),
        .i_retire_halt(retire_halt), .i_retire_trap(retire_trap),
        .i_retire_pc(retire_pc),
`ifdef HART_RUN_CTRL_BKPT_EN
        .i_bkpt_en(bkpt_en), .i_bkpt_pc(bkpt_pc), .o_bkpt_hit(l_bkpt_hit),
`endif
        .o_hart_rst(l_hart_rst), .o_hart_en(l_hart_en), .o_state(l_state),
        .o_cycle_count(l_cyc), .o_retire_count(l_ret), .o_trap_seen(l_trap_seen),
        .o_timeout(l_timeout)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Outputs are read 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] c);
        cmd_valid = 1'b1;
        cmd       = c;
        step();
        cmd_valid = 1'b0;
    endtask

    // Asynchronous reset landing mid-cycle, then release and count hart_rst cycles.
    task automatic rst_pulse(input string tag);
        int n_rst;
        rst = 1'b1;
        #1;
        check_eq({tag, ".async_state"}, 32'(state), 32'd0);
        check_eq({tag, ".async_en"}, 32'(hart_en), 32'd0);
        check_eq({tag, ".async_hrst"}, 32'(hart_rst), 32'd1);
        check_eq({tag, ".async_ready"}, 32'(cmd_ready), 32'd0);
        check_eq({tag, ".async_cyc"}, cyc, 32'd0);
        check_eq({tag, ".async_flags"}, {30'd0, trap_seen, l_timeout}, 32'd0);
        step();
        rst   = 1'b0;
        n_rst = 0;
        for (int i = 0; i < 6; i++) begin
            if (hart_rst) n_rst++;
            step();
        end
        check_eq({tag, ".hrst_cycles"}, 32'(n_rst), 32'd2);
        check_eq({tag, ".state_stopped"}, 32'(state), 32'd1);
        check_eq({tag, ".ready"}, 32'(cmd_ready), 32'd1);
        check_eq({tag, ".counts"}, cyc | ret, 32'd0);
    endtask

    initial begin
        int n_en;
        step();

        // Reset sequence
        rst_pulse("rst0");

        // STEP x3 with retire_valid held high
        retire_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            send(2'b01);
            check_eq($sformatf("step%0d.en", k), 32'(hart_en), 32'd1);
            check_eq($sformatf("step%0d.state", k), 32'(state), 32'd3);
            check_eq($sformatf("step%0d.ready", k), 32'(cmd_ready), 32'd0);
            step();
            check_eq($sformatf("step%0d.en_off", k), 32'(hart_en), 32'd0);
            check_eq($sformatf("step%0d.back", k), 32'(state), 32'd1);
        end
        repeat (3) step();
        check_eq("step.retire", ret, 32'd3);
        check_eq("step.cycles", cyc, 32'd3);

        // RUN, halt on 10th enabled cycle together with STOP
        rst_pulse("rst1");
        send(2'b00);
        check_eq("run.state", 32'(state), 32'd2);
        check_eq("run.cyc0", cyc, 32'd0);
        repeat (9) step();
        check_eq("run.cyc9", cyc, 32'd9);
        retire_halt = 1'b1;
        cmd_valid   = 1'b1;
        cmd         = 2'b10;
        step();
        cmd_valid   = 1'b0;
        retire_halt = 1'b0;
        check_eq("halt.state", 32'(state), 32'd4);
        check_eq("halt.cyc", cyc, 32'd10);
        check_eq("halt.ret", ret, 32'd10);
        check_eq("halt.en", 32'(hart_en), 32'd0);
        check_eq("halt.timeout_unlim", 32'(timeout), 32'd0);
        send(2'b00);
        step();
        check_eq("halt.run_ignored", 32'(state), 32'd4);
        check_eq("halt.cyc_frozen", cyc, 32'd10);
        check_eq("halt.ready", 32'(cmd_ready), 32'd1);

        // CYCLE_LIMIT=5 instance times out
        retire_valid = 1'b0;
        rst_pulse("rst2");
        send(2'b00);
        n_en = 0;
        for (int i = 0; i < 4; i++) begin
            if (l_hart_en) n_en++;
            step();
        end
        check_eq("lim.cyc4", l_cyc, 32'd4);
        check_eq("lim.pre_timeout", 32'(l_timeout), 32'd0);
        for (int i = 0; i < 6; i++) begin
            if (l_hart_en) n_en++;
            step();
        end
        check_eq("lim.en_cycles", 32'(n_en), 32'd5);
        check_eq("lim.cyc", l_cyc, 32'd5);
        check_eq("lim.timeout", 32'(l_timeout), 32'd1);
        check_eq("lim.state", 32'(l_state), 32'd4);
        check_eq("unlim.still_running", 32'(state), 32'd2);

        // Trap on cycle 3, STOP on cycle 6, then host RESET
        rst_pulse("rst3");
        send(2'b00);
        step();
        step();
        retire_valid = 1'b1;
        retire_trap  = 1'b1;
        step();
        retire_valid = 1'b0;
        retire_trap  = 1'b0;
        check_eq("trap.seen", 32'(trap_seen), 32'd1);
        check_eq("trap.state", 32'(state), 32'd2);
        step();
        step();
        send(2'b10);
        check_eq("trapstop.state", 32'(state), 32'd1);
        check_eq("trapstop.cyc", cyc, 32'd6);
        check_eq("trapstop.ret", ret, 32'd1);
        check_eq("trapstop.sticky", 32'(trap_seen), 32'd1);
        send(2'b11);
        check_eq("cmdrst.state", 32'(state), 32'd0);
        check_eq("cmdrst.hrst", 32'(hart_rst), 32'd1);
        check_eq("cmdrst.cyc", cyc, 32'd0);
        check_eq("cmdrst.trap", 32'(trap_seen), 32'd0);
        step();
        check_eq("cmdrst.seq2", 32'(state), 32'd0);
        step();
        check_eq("cmdrst.done", 32'(state), 32'd1);
        check_eq("cmdrst.hrst_off", 32'(hart_rst), 32'd0);

`ifdef HART_RUN_CTRL_BKPT_EN
        // Breakpoint stops a run and RUN clears the hit flag
        rst_pulse("rst4");
        bkpt_en      = 1'b1;
        bkpt_pc      = 32'h10;
        retire_valid = 1'b1;
        retire_pc    = 32'h4;
        send(2'b00);
        step();
        retire_pc = 32'h10;
        step();
        retire_pc = 32'h0;
        check_eq("bkpt.state", 32'(state), 32'd1);
        check_eq("bkpt.hit", 32'(bkpt_hit), 32'd1);
        check_eq("bkpt.en", 32'(hart_en), 32'd0);
        send(2'b00);
        check_eq("bkpt.cleared", 32'(bkpt_hit), 32'd0);
        check_eq("bkpt.rerun", 32'(state), 32'd2);
        send(2'b10);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hart_run_ctrl.md
HART_RUN_CTRL -- requirements
Module: hart_run_ctrl

Interface
REQ-001 Parameter RST_CYCLES, default 2, cycles o_hart_rst is held during a reset sequence (range 1..15).
REQ-002 Parameter CYCLE_LIMIT, default 0, maximum enabled cycles per run; 0 means unlimited.
REQ-003 i_clk  in  1  single clock; all state updates on rising edge.
REQ-004 i_rst  in  1  reset, asynchronous and active-high.
REQ-005 i_cmd_valid  in  1  host command strobe; i_cmd  in  2  00=RUN, 01=STEP, 10=STOP, 11=RESET; o_cmd_ready  out  1  command accepted when valid&ready.
REQ-006 i_retire_valid, i_retire_halt, i_retire_trap  in  1 each  hart retire signals; i_retire_pc  in  32  retired PC.
REQ-007 o_hart_rst  out  1  synchronous reset to hart; o_hart_en  out  1  hart advances this cycle.
REQ-008 o_state  out  3  current FSM state; o_cycle_count  out  32; o_retire_count  out  32; o_trap_seen  out  1; o_timeout  out  1.

Function
REQ-009 FSM states: RST_SEQ=0, STOPPED=1, RUNNING=2, STEPPING=3, HALTED=4; o_state shows encoding.
REQ-010 RST_SEQ: o_hart_rst=1, o_hart_en=0 for exactly RST_CYCLES cycles, counters and flags cleared, then STOPPED.
REQ-011 o_cmd_ready=0 in RST_SEQ and STEPPING, 1 otherwise; commands are ignored while not ready.
REQ-012 STOPPED: RUN -> RUNNING; STEP -> STEPPING; STOP -> no change; RESET -> RST_SEQ.
REQ-013 RUNNING: o_hart_en=1 every cycle; STOP -> STOPPED next cycle (accepted cycle still enabled); RESET -> RST_SEQ.
REQ-014 STEPPING: o_hart_en=1 for exactly one cycle, then STOPPED, unless a halt/limit condition sends it to HALTED.
REQ-015 HALTED: o_hart_en=0; only RESET is acted on; RUN, STEP and STOP are accepted and discarded.
REQ-016 Retire inputs are sampled only in cycles with o_hart_en=1.
REQ-017 Enabled cycle with i_retire_valid&i_retire_halt -> HALTED next cycle; halt wins over a same-cycle STOP command.
REQ-018 Enabled cycle with i_retire_valid&i_retire_trap sets o_trap_seen (sticky until RST_SEQ); no state change.
REQ-019 o_cycle_count increments by 1 per enabled cycle; o_retire_count increments per enabled cycle with i_retire_valid; both wrap modulo 2^32.
REQ-020 CYCLE_LIMIT!=0: the enabled cycle in which o_cycle_count reaches CYCLE_LIMIT sets o_timeout (sticky) and forces HALTED next cycle; simultaneous retire halt also -> HALTED, both flags valid.
REQ-021 o_hart_en and o_hart_rst are registered outputs decoded from state; never both 1.

Reset
REQ-022 i_rst asserted, at any time including mid-run: state=RST_SEQ, RST_SEQ counter loaded, o_hart_rst=1, o_hart_en=0, counters=0, o_trap_seen=0, o_timeout=0, o_cmd_ready=0.
REQ-023 After i_rst deasserts, the RST_SEQ completes the full RST_CYCLES count before STOPPED.

Configuration
REQ-024 Macro HART_RUN_CTRL_BKPT_EN defined: adds ports i_bkpt_en in 1 and i_bkpt_pc in 32, plus o_bkpt_hit out 1.
REQ-025 With it: enabled cycle with i_retire_valid & i_bkpt_en & i_retire_pc==i_bkpt_pc -> STOPPED next cycle, o_bkpt_hit=1 until next accepted RUN/STEP/RESET; halt has priority over breakpoint.
REQ-026 Without it: ports absent, no breakpoint logic, behaviour otherwise identical.

Structure
REQ-027 Shared package hart_ctrl_pkg holds the state enum, command encoding constants, and RST_CYCLES width.
REQ-028 One sub-module hart_run_counters (cycle/retire counters, limit compare) is natural; FSM stays in hart_run_ctrl.

Verification
REQ-029 Reset: i_rst pulse, RST_CYCLES=2 -> o_hart_rst high 2 cycles after release, then o_state=1, counts 0.
REQ-030 STEP x3 from STOPPED with retire_valid=1 -> three single o_hart_en pulses, o_retire_count=3, state returns to 1.
REQ-031 RUN, retire_halt at 10th enabled cycle with STOP same cycle -> o_state=4, o_cycle_count=10, further RUN ignored.
REQ-032 CYCLE_LIMIT=5, RUN with no halt -> exactly 5 enabled cycles, o_timeout=1, o_state=4.
REQ-033 Trap on cycle 3 of RUN, STOP on cycle 6 -> o_trap_seen=1, o_state=1, o_cycle_count=6; RESET clears all.
REQ-034 BKPT_EN, i_bkpt_pc=0x10, retire pc 0x10 -> o_state=1, o_bkpt_hit=1; RUN clears o_bkpt_hit.
